sobel_stream: RTL
=================

# sobel_stream

Parametrised streaming Sobel edge-magnitude engine: the next generation of the fixed 64-column Sobel stage in the edge-detection datapath. It accepts a raster pixel stream and builds 3x3 windows from two line buffers. It computes Gx/Gy and emits one saturated magnitude per interior pixel, with row/frame markers and full ready/valid backpressure toward the pooling stage. Magnitude uses L1 or alpha-max/beta-min L2 approximation, so no CORDIC or multiplier is needed, plus optional runtime thresholding.

## Interface
Parameters:
- IMG_W, 64, pixels per row (>=3)
- IMG_H, 64, rows per frame (>=3)
- PIX_W, 8, input pixel width, unsigned
- OUT_W, 12, output magnitude width
- MAG_MODE, 0, 0 = |Gx|+|Gy|; 1 = max(|Gx|,|Gy|) + (min(|Gx|,|Gy|)>>1)

Ports:
- clk_200mhz  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pixel_in  in  PIX_W  raster pixel
- valid_in  in  1  pixel_in valid
- sof_in  in  1  qualifies pixel_in as frame pixel (0,0)
- ready_out  out  1  block accepts a pixel this cycle
- thr_en  in  1  threshold mode enable
- threshold  in  OUT_W  threshold value
- pixel_out  out  OUT_W  magnitude or binary edge
- valid_out  out  1  pixel_out valid
- eol_out  out  1  last output of a row
- eof_out  out  1  last output of a frame
- ready_in  in  1  downstream accepts output

## Operation
- Accept = valid_in & ready_out. Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance per accept; col wraps at IMG_W-1 and increments row; row wraps at IMG_H-1 to 0, which starts the next frame.
- sof_in on an accepted pixel forces that pixel to (0,0) regardless of counter state. Partial windows from the aborted frame never produce output.
- Two line buffers of IMG_W x PIX_W hold rows row-1 and row-2, written at index col. They are not reset. The window shifts left one column per accept, new column = {lb2[col], lb1[col], pixel_in}.
- A window is valid iff the accepted pixel has col>=2 and row>=2. Its output corresponds to center (row-1, col-1). Per frame: IMG_W-2 outputs per row, (IMG_W-2)*(IMG_H-2) total. Border pixels produce no output.
- Gx = (r0c2-r0c0) + 2(r1c2-r1c0) + (r2c2-r2c0). Gy = (r2c0-r0c0) + 2(r2c1-r0c1) + (r2c2-r0c2). Both signed, PIX_W+3 bits, no overflow possible.
- |Gx|, |Gy|: PIX_W+2 bits unsigned.
- Magnitude is formed per MAG_MODE in PIX_W+3 bits, then saturated to 2^OUT_W-1.
- thr_en/threshold are sampled on the accept of pixel (0,0) and held for the frame; mid-frame changes are ignored. When the sampled thr_en=1, pixel_out = all-ones if mag >= threshold, else 0. Comparison uses the pre-saturation magnitude.
- eol_out is set with the output at center col IMG_W-2. eof_out is set with the output at center (IMG_H-2, IMG_W-2), together with eol_out.
- Pipeline: S0 window/line-buffer update; S1 column differences; S2 Gx,Gy; S3 abs; S4 magnitude/saturate/threshold into the output register. Valid, eol and eof bits travel with the data.

## Timing
- Reset: pixel_out=0, valid_out=0, eol_out=0, eof_out=0. Counters=0, all stage valids=0, sampled thr_en=0. ready_out=1 after reset because it is combinational from valid_out.
- Global advance enable ce = ~valid_out | ready_in; ready_out = ce. When ce=0, every stage, counter and line buffer holds, and pixel_out/valid_out/eol_out/eof_out are stable.
- Latency: with ce=1 throughout, a window-completing pixel accepted at edge k gives valid_out=1 after edge k+4 (5 register stages). Each stall cycle adds exactly one cycle.
- Throughput: one pixel per cycle when ready_in=1 continuously; valid_in gaps insert bubbles (stage valid=0) without losing data.
- Output handshake: a word is consumed on valid_out & ready_in. No word is dropped or duplicated.
- Reset asserted mid-frame: outputs clear within the same cycle (asynchronous). The next accepted pixel is (0,0) whether or not sof_in is set.
- sof_in together with ce=0 has no effect, because the pixel is not accepted.

## Test plan
Bench params: IMG_W=8, IMG_H=6, PIX_W=8, OUT_W=12, ready_in=1 unless stated.
- Constant 50 frame -> exactly 24 outputs, all 0; eol_out on every 6th output; eof_out only on the 24th; first valid_out 4 cycles after pixel (2,2) accepted.
- Vertical step (cols 0-3 = 0, cols 4-7 = 100) -> per row outputs 0,0,400,400,0,0 for both MAG_MODE=0 and 1.
- Diagonal: Gx=Gy=400 window (MAG_MODE=1) -> 600; MAG_MODE=0 -> 800; with OUT_W=8 -> 255 saturated.
- Step image with thr_en=1, threshold=300 -> 4095 at step columns, 0 elsewhere. thr_en toggled mid-frame -> no change until next frame.
- ready_in low 5 cycles mid-row -> ready_out low, outputs stable, total 24 outputs, sequence identical to the no-stall run.
- sof_in asserted at row 3 col 5 -> counters resync and a full 24-output frame follows. Reset pulse mid-frame -> all outputs 0 immediately, and a clean frame follows.

Source files
------------

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge-magnitude engine: raster pixels in, one saturated
// (or thresholded) magnitude per interior pixel out, with row/frame markers.
module sobel_stream #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int PIX_W    = 8,
    parameter int OUT_W    = 12,
    parameter int MAG_MODE = 0
) (
    input  logic             clk_200mhz,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             valid_in,
    input  logic             sof_in,
    output logic             ready_out,
    input  logic             thr_en,
    input  logic [OUT_W-1:0] threshold,
    output logic [OUT_W-1:0] pixel_out,
    output logic             valid_out,
    output logic             eol_out,
    output logic             eof_out,
    input  logic             ready_in
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DW = PIX_W + 1;
    localparam int GW = PIX_W + 3;
    localparam int AW = PIX_W + 2;
    localparam int MW = PIX_W + 3;
    localparam int EW = (MW > OUT_W) ? MW : OUT_W;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    function automatic logic signed [GW-1:0] sext(input logic signed [DW-1:0] d);
        return {{(GW-DW){d[DW-1]}}, d};
    endfunction

    function automatic logic [AW-1:0] abs_val(input logic signed [GW-1:0] g);
        return AW'((g < 0) ? -g : g);
    endfunction

    function automatic logic [MW-1:0] magnitude(input logic [AW-1:0] ax, input logic [AW-1:0] ay);
        logic [AW-1:0] hi;
        logic [AW-1:0] lo;
        hi = (ax >= ay) ? ax : ay;
        lo = (ax >= ay) ? ay : ax;
        if (MAG_MODE == 0)
            return MW'(ax) + MW'(ay);
        else
            return MW'(hi) + MW'(lo >> 1);
    endfunction

    function automatic logic [OUT_W-1:0] saturate(input logic [MW-1:0] m);
        logic [EW-1:0] ext;
        ext = EW'(m);
        if (ext > EW'({OUT_W{1'b1}}))
            return '1;
        else
            return OUT_W'(ext);
    endfunction

    // Threshold compares against the unsaturated magnitude.
    function automatic logic [OUT_W-1:0] output_word(input logic on, input logic [OUT_W-1:0] thr,
                                                     input logic [MW-1:0] m);
        if (on)
            return (EW'(m) >= EW'(thr)) ? '1 : '0;
        else
            return saturate(m);
    endfunction

    logic            ce, acc;
    logic [CW-1:0]   col, eff_col;
    logic [RW-1:0]   row, eff_row;
    logic            win_ok, line_end, frame_end, at_origin;
    logic            thr_en_f;
    logic [OUT_W-1:0] thr_f;

    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    logic [PIX_W-1:0]        win_p0 [3][3];
    logic signed [DW-1:0]    dx_p1 [3];
    logic signed [DW-1:0]    dy_p1 [3];
    logic signed [GW-1:0]    gx_p2, gy_p2;
    logic [AW-1:0]           ax_p3, ay_p3;
    logic                    vld_p0, vld_p1, vld_p2, vld_p3;
    logic                    eol_p0, eol_p1, eol_p2, eol_p3;
    logic                    eof_p0, eof_p1, eof_p2, eof_p3;
    logic                    thr_on_p0, thr_on_p1, thr_on_p2, thr_on_p3;
    logic [OUT_W-1:0]        thr_p0, thr_p1, thr_p2, thr_p3;
    logic [OUT_W-1:0]        result_p3;

    assign ce        = ~valid_out | ready_in;
    assign ready_out = ce;
    assign acc       = valid_in & ce;
    assign eff_col   = sof_in ? '0 : col;
    assign eff_row   = sof_in ? '0 : row;
    assign win_ok    = (eff_col >= CW'(2)) && (eff_row >= RW'(2));
    assign line_end  = (eff_col == COL_LAST);
    assign frame_end = line_end && (eff_row == ROW_LAST);
    assign at_origin = (eff_col == '0) && (eff_row == '0);
    assign result_p3 = output_word(thr_on_p3, thr_p3, magnitude(ax_p3, ay_p3));

    always_ff @(posedge clk_200mhz or posedge reset) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            thr_en_f  <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            eol_p0    <= 1'b0;
            eol_p1    <= 1'b0;
            eol_p2    <= 1'b0;
            eol_p3    <= 1'b0;
            eof_p0    <= 1'b0;
            eof_p1    <= 1'b0;
            eof_p2    <= 1'b0;
            eof_p3    <= 1'b0;
            pixel_out <= '0;
            valid_out <= 1'b0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
        end else if (ce) begin
            if (acc) begin
                if (line_end) begin
                    col <= '0;
                    row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
                end else begin
                    col <= eff_col + CW'(1);
                    row <= eff_row;
                end
                if (at_origin)
                    thr_en_f <= thr_en;
            end
            vld_p0    <= acc & win_ok;
            eol_p0    <= acc & win_ok & line_end;
            eof_p0    <= acc & win_ok & frame_end;
            vld_p1    <= vld_p0;
            eol_p1    <= eol_p0;
            eof_p1    <= eof_p0;
            vld_p2    <= vld_p1;
            eol_p2    <= eol_p1;
            eof_p2    <= eof_p1;
            vld_p3    <= vld_p2;
            eol_p3    <= eol_p2;
            eof_p3    <= eof_p2;
            valid_out <= vld_p3;
            eol_out   <= eol_p3;
            eof_out   <= eof_p3;
            if (vld_p3)
                pixel_out <= result_p3;
        end
    end

    always_ff @(posedge clk_200mhz) begin
        if (ce) begin
            // S0: line buffers and window shift
            if (acc) begin
                lb1[eff_col] <= pixel_in;
                lb2[eff_col] <= lb1[eff_col];
                for (int r = 0; r < 3; r++) begin
                    win_p0[r][0] <= win_p0[r][1];
                    win_p0[r][1] <= win_p0[r][2];
                end
                win_p0[0][2] <= lb2[eff_col];
                win_p0[1][2] <= lb1[eff_col];
                win_p0[2][2] <= pixel_in;
                if (at_origin)
                    thr_f <= threshold;
                thr_on_p0 <= thr_en_f;
                thr_p0    <= thr_f;
            end
            // S1: column and row differences
            for (int i = 0; i < 3; i++) begin
                dx_p1[i] <= $signed({1'b0, win_p0[i][2]}) - $signed({1'b0, win_p0[i][0]});
                dy_p1[i] <= $signed({1'b0, win_p0[2][i]}) - $signed({1'b0, win_p0[0][i]});
            end
            thr_on_p1 <= thr_on_p0;
            thr_p1    <= thr_p0;
            // S2: weighted sums
            gx_p2     <= sext(dx_p1[0]) + (sext(dx_p1[1]) <<< 1) + sext(dx_p1[2]);
            gy_p2     <= sext(dy_p1[0]) + (sext(dy_p1[1]) <<< 1) + sext(dy_p1[2]);
            thr_on_p2 <= thr_on_p1;
            thr_p2    <= thr_p1;
            // S3: absolute values; S4 is the output register above
            ax_p3     <= abs_val(gx_p2);
            ay_p3     <= abs_val(gy_p2);
            thr_on_p3 <= thr_on_p2;
            thr_p3    <= thr_p2;
        end
    end

endmodule
